// File: rtl/adma_chn_wrr_arb.sv
// Weighted round-robin arbiter sharing the DMA read port among channels.
// Latency: request sampled in IDLE gives a registered grant on the next cycle; at most one grant every 2 cycles.
// Backpressure: grant is held stable until gnt_ready_i; no new request is sampled while a grant is pending.
module adma_chn_wrr_arb #(
    parameter int DMA_CHN_NUM   = 4,
    parameter int DMA_CHN_ARB_W = 3,
    parameter int CHN_ID_W      = $clog2(DMA_CHN_NUM)
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic                                   arb_en_i,
    input  logic [DMA_CHN_NUM-1:0]                 chn_req_i,
    input  logic [DMA_CHN_NUM*DMA_CHN_ARB_W-1:0]   chn_weight_i,
    output logic [DMA_CHN_NUM-1:0]                 chn_ack_o,
    output logic                                   gnt_valid_o,
    output logic [CHN_ID_W-1:0]                    gnt_id_o,
    input  logic                                   gnt_ready_i
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [CHN_ID_W-1:0]        ptr_q, ptr_d;
    logic [CHN_ID_W-1:0]        gnt_id_q, gnt_id_d;
    logic [DMA_CHN_ARB_W-1:0]   credit_q, credit_d;
    logic                       gnt_valid_q, gnt_valid_d;

    logic [DMA_CHN_NUM-1:0]     elig;
    logic                       rot_found;
    logic [CHN_ID_W-1:0]        rot_sel;
    logic [CHN_ID_W-1:0]        scan_idx;
    logic [DMA_CHN_ARB_W-1:0]   rot_weight;
    logic                       stay;

    // A zero weight masks the channel entirely.
    always_comb begin
        elig = '0;
        for (int c = 0; c < DMA_CHN_NUM; c++) begin
            elig[c] = chn_req_i[c] & (|chn_weight_i[c*DMA_CHN_ARB_W +: DMA_CHN_ARB_W]);
        end
    end

    // Scan ptr+1 .. ptr+N; walking downward lets the nearest hit overwrite farther ones.
    always_comb begin
        rot_found = 1'b0;
        rot_sel   = ptr_q;
        scan_idx  = '0;
        for (int k = DMA_CHN_NUM; k >= 1; k--) begin
            scan_idx = CHN_ID_W'((int'(ptr_q) + k) % DMA_CHN_NUM);
            if (elig[scan_idx]) begin
                rot_found = 1'b1;
                rot_sel   = scan_idx;
            end
        end
    end

    always_comb begin
        rot_weight = '0;
        for (int c = 0; c < DMA_CHN_NUM; c++) begin
            if (rot_sel == CHN_ID_W'(c)) begin
                rot_weight = chn_weight_i[c*DMA_CHN_ARB_W +: DMA_CHN_ARB_W];
            end
        end
    end

    assign stay = elig[ptr_q] && (credit_q != '0);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        credit_d    = credit_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        case (state_q)
            IDLE: begin
                if (arb_en_i && rot_found) begin
                    state_d     = GRANT;
                    gnt_valid_d = 1'b1;
                    if (stay) begin
                        gnt_id_d = ptr_q;
                    end else begin
                        gnt_id_d = rot_sel;
                        credit_d = rot_weight;
                    end
                end
            end
            GRANT: begin
                if (gnt_ready_i) begin
                    state_d     = IDLE;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_id_q;
                    credit_d    = credit_q - DMA_CHN_ARB_W'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= IDLE;
            ptr_q       <= CHN_ID_W'(DMA_CHN_NUM - 1);
            credit_q    <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            credit_q    <= credit_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
        end
    end

    always_comb begin
        chn_ack_o = '0;
        if (gnt_valid_q && gnt_ready_i) begin
            chn_ack_o[gnt_id_q] = 1'b1;
        end
    end

    assign gnt_valid_o = gnt_valid_q;
    assign gnt_id_o    = gnt_id_q;

endmodule

// File: tb/tb_adma_chn_wrr_arb.sv
// Bench for adma_chn_wrr_arb: directed test-plan scenarios plus a random run against a burst-budget model.
module tb_adma_chn_wrr_arb;

    localparam int N  = 4;
    localparam int W  = 3;
    localparam int IW = 2;

    logic           aclk = 1'b0;
    logic           areset;
    logic           arb_en_i;
    logic [N-1:0]   chn_req_i;
    logic [N*W-1:0] chn_weight_i;
    logic [N-1:0]   chn_ack_o;
    logic           gnt_valid_o;
    logic [IW-1:0]  gnt_id_o;
    logic           gnt_ready_i;

    always #5 aclk = ~aclk;

    adma_chn_wrr_arb #(
        .DMA_CHN_NUM   (N),
        .DMA_CHN_ARB_W (W),
        .CHN_ID_W      (IW)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .arb_en_i     (arb_en_i),
        .chn_req_i    (chn_req_i),
        .chn_weight_i (chn_weight_i),
        .chn_ack_o    (chn_ack_o),
        .gnt_valid_o  (gnt_valid_o),
        .gnt_id_o     (gnt_id_o),
        .gnt_ready_i  (gnt_ready_i)
    );

    int checks = 0;
    int errors = 0;

    // Reference: an owner keeps the port while it requests and has budget left, else the next eligible channel in circular order takes it.
    bit         m_busy;
    int         m_last;
    int         m_id;
    int         m_budget;
    bit [N-1:0] m_acked;
    int         exp_q[$];
    int         got_q[$];
    bit         mon_on = 1'b0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wt(int c);
        return int'(chn_weight_i[c*W +: W]);
    endfunction

    always @(posedge aclk) begin : model
        int pick;
        int c;
        if (areset) begin
            m_busy   = 1'b0;
            m_last   = N - 1;
            m_budget = 0;
            exp_q.delete();
        end else if (m_busy) begin
            if (gnt_ready_i) begin
                m_busy         = 1'b0;
                m_budget       = m_budget - 1;
                m_last         = m_id;
                m_acked[m_id]  = 1'b1;
            end
        end else if (arb_en_i) begin
            pick = -1;
            if (chn_req_i[m_last] && wt(m_last) != 0 && m_budget > 0) begin
                pick = m_last;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (pick < 0 && chn_req_i[c] && wt(c) != 0) begin
                        pick     = c;
                        m_budget = wt(c);
                    end
                end
            end
            if (pick >= 0) begin
                m_busy = 1'b1;
                m_id   = pick;
                exp_q.push_back(pick);
            end
        end
    end

    always @(negedge aclk) begin : monitor
        logic [N-1:0] exp_ack;
        if (mon_on) begin
            check("gnt_valid", int'(gnt_valid_o), int'(m_busy));
            exp_ack = '0;
            if (m_busy && gnt_ready_i && exp_q.size() > 0) exp_ack = N'(1) << exp_q[0];
            check("chn_ack", int'(chn_ack_o), int'(exp_ack));
            if (gnt_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("grant_expected", 0, 1);
                end else begin
                    check("gnt_id", int'(gnt_id_o), exp_q[0]);
                    if (gnt_ready_i) begin
                        got_q.push_back(int'(gnt_id_o));
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic do_reset();
        gnt_ready_i = 1'b0;
        areset      = 1'b1;
        tick();
        tick();
        areset  = 1'b0;
        m_acked = '0;
        got_q.delete();
    endtask

    task automatic run_grants(int n, int budget);
        int cyc = 0;
        while (got_q.size() < n && cyc < budget) begin
            tick();
            cyc++;
        end
        if (got_q.size() < n) check("grant_timeout", got_q.size(), n);
    endtask

    task automatic wait_valid(int budget);
        int cyc = 0;
        while (!gnt_valid_o && cyc < budget) begin
            tick();
            cyc++;
        end
        if (!gnt_valid_o) check("valid_timeout", 0, 1);
    endtask

    task automatic expect_seq(string name, int exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            check(name, (i < got_q.size()) ? got_q[i] : -1, exp[i]);
        end
    endtask

    initial begin
        areset       = 1'b1;
        arb_en_i     = 1'b0;
        chn_req_i    = '0;
        chn_weight_i = '0;
        gnt_ready_i  = 1'b0;
        m_acked      = '0;
        tick();
        tick();
        mon_on = 1'b1;
        areset = 1'b0;
        @(negedge aclk);
        check("rst_valid", int'(gnt_valid_o), 0);
        check("rst_id", int'(gnt_id_o), 0);
        check("rst_ack", int'(chn_ack_o), 0);
        tick();

        // Equal weights: plain round robin.
        do_reset();
        chn_weight_i = {3'd1, 3'd1, 3'd1, 3'd1};
        arb_en_i     = 1'b1;
        chn_req_i    = 4'b1111;
        gnt_ready_i  = 1'b1;
        run_grants(8, 100);
        expect_seq("rr_order", '{0, 1, 2, 3, 0, 1, 2, 3});

        // Weights {3,1,2,1}.
        do_reset();
        chn_weight_i = {3'd1, 3'd2, 3'd1, 3'd3};
        gnt_ready_i  = 1'b1;
        run_grants(14, 100);
        expect_seq("wrr_order", '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3});

        // Channel 2 masked by zero weight.
        do_reset();
        chn_weight_i = {3'd1, 3'd0, 3'd1, 3'd1};
        gnt_ready_i  = 1'b1;
        run_grants(8, 100);
        expect_seq("mask_order", '{0, 1, 3, 0, 1, 3, 0, 1});

        // Backpressure: grant to channel 1 held for 5 cycles.
        do_reset();
        chn_weight_i = {3'd1, 3'd1, 3'd1, 3'd1};
        chn_req_i    = 4'b0010;
        wait_valid(20);
        repeat (5) begin
            @(negedge aclk);
            check("hold_valid", int'(gnt_valid_o), 1);
            check("hold_id", int'(gnt_id_o), 1);
            check("hold_ack", int'(chn_ack_o), 0);
        end
        @(posedge aclk);
        #2;
        gnt_ready_i = 1'b1;
        @(negedge aclk);
        check("bp_ack", int'(chn_ack_o), 4'b0010);
        tick();
        chn_req_i = '0;
        repeat (4) tick();
        check("bp_ack_count", got_q.size(), 1);

        // Early request drop rotates immediately.
        do_reset();
        chn_weight_i = {3'd1, 3'd1, 3'd1, 3'd4};
        chn_req_i    = 4'b1001;
        gnt_ready_i  = 1'b1;
        begin
            int cyc = 0;
            while (got_q.size() < 2 && cyc < 50) begin
                tick();
                cyc++;
            end
        end
        chn_req_i[0] = 1'b0;
        run_grants(3, 50);
        expect_seq("drop_order", '{0, 0, 3});

        // Reset while a grant to channel 2 is pending.
        do_reset();
        chn_weight_i = {3'd1, 3'd1, 3'd1, 3'd1};
        chn_req_i    = 4'b0100;
        wait_valid(20);
        check("pre_rst_id", int'(gnt_id_o), 2);
        areset = 1'b1;
        tick();
        areset      = 1'b0;
        chn_req_i   = 4'b1111;
        gnt_ready_i = 1'b1;
        @(negedge aclk);
        check("post_rst_valid", int'(gnt_valid_o), 0);
        check("no_ack_ch2", got_q.size(), 0);
        run_grants(1, 20);
        expect_seq("post_rst_first", '{0});

        // Random traffic against the model.
        do_reset();
        chn_req_i = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            arb_en_i    = ($urandom % 10) != 0;
            gnt_ready_i = ($urandom % 3) != 0;
            if ($urandom % 50 == 0) chn_weight_i = N*W'($urandom);
            for (int c = 0; c < N; c++) begin
                if (!chn_req_i[c]) chn_req_i[c] = ($urandom % 3) == 0;
                else if (m_acked[c]) chn_req_i[c] = ($urandom % 2) == 0;
            end
            m_acked = '0;
            if ($urandom % 500 == 0) begin
                areset      = 1'b1;
                gnt_ready_i = 1'b0;
                tick();
                areset  = 1'b0;
                m_acked = '0;
            end else begin
                tick();
            end
        end
        check("random_grants_seen", int'(got_q.size() > 50), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adma_chn_wrr_arb.md
# adma_chn_wrr_arb

Weighted round-robin arbiter that shares the DMA's single AXI4 read (source) port among `DMA_CHN_NUM` channels. Each channel raises a burst request when it has a source burst ready to issue. The arbiter selects one channel at a time and presents its index to the read host as a valid/ready grant. Per-channel weights come from the register map and set how many back-to-back bursts a channel may take before the arbiter rotates.

## Interface
- `DMA_CHN_NUM`, 4: number of requesting channels (≥2).
- `DMA_CHN_ARB_W`, 3: width of each channel weight.
- `CHN_ID_W`, $clog2(DMA_CHN_NUM): width of the grant index.

Ports:
- `aclk`  in  1  single clock; all logic on its rising edge.
- `areset`  in  1  reset, synchronous and active-high.
- `arb_en_i`  in  1  global enable; when low, no new grant is issued.
- `chn_req_i`  in  DMA_CHN_NUM  per-channel burst request; bit c belongs to channel c.
- `chn_weight_i`  in  DMA_CHN_NUM*DMA_CHN_ARB_W  weights; channel c uses bits [c*W +: W].
- `chn_ack_o`  out  DMA_CHN_NUM  one-hot, one-cycle acknowledge of the channel whose grant was accepted.
- `gnt_valid_o`  out  1  grant valid toward the read host.
- `gnt_id_o`  out  CHN_ID_W  granted channel index.
- `gnt_ready_i`  in  1  read host accepts the grant.

## Operation
- State held by the block:
  - FSM with two states, IDLE and GRANT.
  - `ptr`: index of the last accepted channel.
  - `credit`: DMA_CHN_ARB_W-bit counter.
- Eligibility: channel c is eligible when `chn_req_i[c]` = 1 and `weight[c]` ≠ 0. A channel with weight 0 is masked and is never granted.
- IDLE:
  - If `arb_en_i` = 0 or no channel is eligible, stay in IDLE.
  - Stay rule: if channel `ptr` is eligible and `credit` ≠ 0, select `ptr` and leave `credit` unchanged.
  - Rotate rule: otherwise select the first eligible channel scanning `ptr+1`, `ptr+2`, … modulo DMA_CHN_NUM, and load `credit` ← `weight[sel]`.
  - Either way, register `gnt_id_o` ← sel and `gnt_valid_o` ← 1, then go to GRANT.
- GRANT:
  - Hold `gnt_valid_o` and `gnt_id_o` stable until `gnt_ready_i` = 1.
  - On the handshake: `chn_ack_o[gnt_id_o]` = 1 in the same cycle (combinational, valid & ready), `credit` ← `credit` − 1, `ptr` ← `gnt_id_o`, `gnt_valid_o` ← 0, next state IDLE.
- Net effect: a channel with weight w receives up to w consecutive grants while it keeps requesting, then the arbiter rotates. If the channel drops its request early, the arbiter rotates immediately.
- Requests are sampled only in IDLE. A requester must hold `chn_req_i` until its `chn_ack_o` pulse. A request that deasserts while its grant is pending does not withdraw the grant.
- Weights are sampled only when `credit` is loaded. A weight change mid-run takes effect at that channel's next rotate-in.
- `arb_en_i` falling during GRANT does not cancel the pending grant; the block returns to IDLE and then stalls there.
- `credit` never underflows: a handshake only occurs after a load of a value ≥1 or a stay with `credit` ≠ 0.

## Timing
- Reset values: state = IDLE; `ptr` = DMA_CHN_NUM−1, so channel 0 wins the first arbitration; `credit` = 0; `gnt_valid_o` = 0; `gnt_id_o` = 0; `chn_ack_o` = 0.
- Latency: request sampled in IDLE at cycle N gives `gnt_valid_o` = 1 at cycle N+1.
- Handshake at cycle M gives `gnt_valid_o` = 0 at M+1; the next grant is visible at M+2 at the earliest.
- Maximum throughput: one grant every 2 cycles.
- `areset` asserted in any state, including GRANT with a pending grant, returns every register to its reset value on the next edge. The pending grant is dropped and no ack is issued.
- `gnt_valid_o`, `gnt_id_o`, `ptr` and `credit` are registered. `chn_ack_o` is combinational from `gnt_valid_o` & `gnt_ready_i`.

## Test plan
- Reset, then all four channels requesting, weights all 1, `gnt_ready_i` tied 1 → grant order 0,1,2,3,0,… with one grant every 2 cycles and an ack pulse matching each grant.
- Weights {3,1,2,1}, all channels requesting continuously → grant sequence 0,0,0,1,2,2,3 repeating.
- Weight of channel 2 = 0 with `chn_req_i[2]` held high; other weights 1 → channel 2 is never granted; order 0,1,3,0,…
- `gnt_ready_i` held low for 5 cycles with channel 1 granted → `gnt_valid_o` = 1 and `gnt_id_o` = 1 stable for all 5 cycles; a single `chn_ack_o` = 0010 when ready rises.
- Channel 0 has weight 4 but drops its request after 2 acks, channel 3 requesting → the next grant goes to channel 3 with no idle grant to channel 0.
- `areset` pulsed while in GRANT with id 2, then all channels requesting → no ack for channel 2 and `gnt_valid_o` = 0 after the reset edge; the first grant after reset is channel 0.
